fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program counter, issues word-addressed requests to instruction memory, buffers in-order responses in a small FIFO, and presents one instruction plus its PC+1 per cycle to IF/ID. Handles hazard stalls by holding its output, and handles taken branches/jumps from ID by redirecting the PC, discarding in-flight responses and raising `flush` to IF/ID.

## Interface
- `PC_W`, 10, PC / instruction-address width (word addresses)
- `INST_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `BUF_DEPTH`, 4, FIFO entries and in-flight credit limit; power of 2, ≥2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hazard unit freeze; hold presented instruction
- `redirect`  in  1  taken branch/jump from ID
- `redirect_pc`  in  PC_W  new fetch address
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  request address (= fetch_pc)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_valid`  in  1  in-order response strobe
- `imem_rdata`  in  INST_W  response data
- `instruction`  out  INST_W  to IF/ID instruction input
- `PC`  out  PC_W  to IF/ID PC input; PC+1 of presented instruction
- `inst_valid`  out  1  presented instruction is real (not bubble)
- `flush`  out  1  to IF/ID flush; equals `redirect`
- `perf_bubbles`  out  16  see Configuration
- `perf_redirects`  out  16  see Configuration

## Operation
- State: `fetch_pc`, `resp_pc`, FIFO of {pc, inst} (`count`), `outstanding` (0..BUF_DEPTH), `drop_cnt` (0..BUF_DEPTH).
- Issue: `imem_req` = !rst & !redirect & (outstanding + count < BUF_DEPTH), registered counts only. Accept = `imem_req & imem_ready`; on accept `fetch_pc` += 1, wrapping at 2^PC_W.
- Response: on `imem_valid` with `outstanding`==0 ignored. If `drop_cnt`>0: discard, decrement. Else push {resp_pc, imem_rdata}, `resp_pc` += 1 (wrap).
- `outstanding`: +1 on accept, −1 on counted response (dropped or pushed); both same cycle → unchanged.
- Output (combinational from FIFO head): count>0 → `instruction`=head.inst, `PC`=head.pc+1 (wrap), `inst_valid`=1; else `instruction`=0, `PC`=0, `inst_valid`=0.
- Pop: count>0 & !stall & !redirect. Push and pop same cycle allowed, count unchanged.
- Stall: no pop; outputs stable; issue/response continue under credit rule.
- Redirect (priority over stall and response push): FIFO cleared; `fetch_pc`←`redirect_pc`; `resp_pc`←`redirect_pc`; `drop_cnt`←`outstanding` − (1 if `imem_valid` this cycle, response also discarded) + existing-drop bookkeeping so every pre-redirect request is dropped; no request issued this cycle; `flush`=1.
- Credit rule guarantees FIFO never overflows; push when full is impossible.

## Timing
- Reset (synchronous): fetch_pc=resp_pc=RESET_PC, count=outstanding=drop_cnt=0; outputs instruction=0, PC=0, inst_valid=0, flush=0, imem_req=0, perf counters 0.
- First cycle after rst low: imem_req=1, imem_addr=RESET_PC.
- 1-cycle memory (ready=1, valid next cycle): request cycle N → response cycle N+1 → presented cycle N+2; steady state one instruction/cycle.
- Redirect in cycle N: flush=1 in N; request to redirect_pc in N+1; its instruction presented N+3 with 1-cycle memory. Back-to-back redirects: last one wins.
- Reset asserted mid-operation: all state cleared next edge; later responses for pre-reset requests are ignored only if outstanding==0 (memory must also reset).

## Configuration
- `FETCH_PERF_EN` defined: `perf_bubbles` counts cycles with !inst_valid & !stall & !rst; `perf_redirects` counts redirect cycles; both 16-bit saturating at 0xFFFF, cleared by rst.
- Undefined: both ports present, tied to 0, no counter logic.

## Test plan
- Reset release, 1-cycle memory returning 0x1000_0000+addr: PCs 1,2,3… and instructions 0x1000_0000,…_0001 on consecutive cycles from cycle 2; imem_addr 0 at cycle 0.
- stall high 3 cycles with head at addr 5: instruction/PC hold 0x1000_0005/6 for 3 cycles; no entries lost; count ≤4.
- redirect to 0x040 with 2 requests outstanding: flush=1 that cycle, both old responses dropped, next valid instruction has PC=0x041.
- redirect coinciding with imem_valid and stall: response discarded, FIFO empty, inst_valid=0 next cycle.
- fetch_pc at 0x3FF: next request address 0x000; presented PC for 0x3FF instruction = 0x000.
- imem_ready low 5 cycles with FETCH_PERF_EN: perf_bubbles increments once per empty cycle; held at 0xFFFF after saturation; without macro reads 0.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage with credit-limited request issue,
//               in-order response FIFO and branch redirect/flush handling.
//               Optional performance counters enabled by FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INST_W    = 32,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic [PC_W-1:0]   PC,
    output logic              inst_valid,
    output logic              flush,
    output logic [15:0]       perf_bubbles,
    output logic [15:0]       perf_redirects
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_resp_pc;
    logic [PC_W-1:0]    r_buf_pc   [BUF_DEPTH];
    logic [INST_W-1:0]  r_buf_inst [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;

    logic [c_CNT_W:0]   w_inflight;
    logic               w_req;
    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_has;

    // Credits cover both buffered entries and requests still in flight
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req      = !rst && !redirect && (w_inflight < (c_CNT_W+1)'(BUF_DEPTH));
    assign w_accept   = w_req && imem_ready;
    assign w_resp     = imem_valid && (r_outstanding != '0);
    assign w_push     = w_resp && (r_drop_cnt == '0) && !redirect;
    assign w_has      = (r_count != '0);
    assign w_pop      = w_has && !stall && !redirect;

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign flush       = redirect;
    assign inst_valid  = w_has;
    assign instruction = w_has ? r_buf_inst[r_rd_ptr] : '0;
    assign PC          = w_has ? r_buf_pc[r_rd_ptr] + PC_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= PC_W'(RESET_PC);
            r_resp_pc     <= PC_W'(RESET_PC);
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(1);
            end
            case ({w_accept, w_resp})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (redirect) begin
                // Every request issued before the redirect must be discarded,
                // including one whose response arrives this very cycle.
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_drop_cnt <= r_outstanding - c_CNT_W'(w_resp);
            end else begin
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
                    r_resp_pc <= r_resp_pc + PC_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
                if (w_resp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_resp_pc;
            r_buf_inst[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_bubbles;
    logic [15:0] r_perf_redirects;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_bubbles   <= '0;
            r_perf_redirects <= '0;
        end else begin
            if (!w_has && !stall && (r_perf_bubbles != 16'hFFFF)) begin
                r_perf_bubbles <= r_perf_bubbles + 16'd1;
            end
            if (redirect && (r_perf_redirects != 16'hFFFF)) begin
                r_perf_redirects <= r_perf_redirects + 16'd1;
            end
        end
    end

    assign perf_bubbles   = r_perf_bubbles;
    assign perf_redirects = r_perf_redirects;
`else
    assign perf_bubbles   = 16'd0;
    assign perf_redirects = 16'd0;
`endif

endmodule

`default_nettype wire
